// File: rtl/rob_retire_pkg.sv
// Shared constants and the ROB row payload for the retirement block.
package rob_retire_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned PREG_W    = 6;
  localparam int unsigned AREG_W    = 5;
  localparam int unsigned NUM_FU    = 3;
  localparam int unsigned IDX_W     = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic              v;
    logic              done;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] old_pd;
  } rob_row;

endpackage

// File: rtl/rob_retire_if.sv
// Dispatch/completion/retire bus between the ROB and its neighbours.
interface rob_retire_if;
  import rob_retire_pkg::*;

  logic                    alloc_valid_1;
  logic [AREG_W-1:0]       alloc_rd_1;
  logic [PREG_W-1:0]       alloc_pd_1;
  logic [PREG_W-1:0]       alloc_old_pd_1;
  logic                    alloc_valid_2;
  logic [AREG_W-1:0]       alloc_rd_2;
  logic [PREG_W-1:0]       alloc_pd_2;
  logic [PREG_W-1:0]       alloc_old_pd_2;
  logic                    alloc_ready;
  logic [IDX_W-1:0]        alloc_idx_1;
  logic [IDX_W-1:0]        alloc_idx_2;
  logic [NUM_FU-1:0]       cmpl_valid;
  logic [NUM_FU*IDX_W-1:0] cmpl_idx;
  logic                    retire_valid_1;
  logic                    retire_valid_2;
  logic [AREG_W-1:0]       retire_rd_1;
  logic [AREG_W-1:0]       retire_rd_2;
  logic [PREG_W-1:0]       retire_pd_1;
  logic [PREG_W-1:0]       retire_pd_2;
  logic                    free_valid_1;
  logic                    free_valid_2;
  logic [PREG_W-1:0]       free_pd_1;
  logic [PREG_W-1:0]       free_pd_2;

  modport master (
    output alloc_valid_1, alloc_rd_1, alloc_pd_1, alloc_old_pd_1,
    output alloc_valid_2, alloc_rd_2, alloc_pd_2, alloc_old_pd_2,
    output cmpl_valid, cmpl_idx,
    input  alloc_ready, alloc_idx_1, alloc_idx_2,
    input  retire_valid_1, retire_valid_2, retire_rd_1, retire_rd_2,
    input  retire_pd_1, retire_pd_2,
    input  free_valid_1, free_valid_2, free_pd_1, free_pd_2
  );

  modport slave (
    input  alloc_valid_1, alloc_rd_1, alloc_pd_1, alloc_old_pd_1,
    input  alloc_valid_2, alloc_rd_2, alloc_pd_2, alloc_old_pd_2,
    input  cmpl_valid, cmpl_idx,
    output alloc_ready, alloc_idx_1, alloc_idx_2,
    output retire_valid_1, retire_valid_2, retire_rd_1, retire_rd_2,
    output retire_pd_1, retire_pd_2,
    output free_valid_1, free_valid_2, free_pd_1, free_pd_2
  );
endinterface

// File: rtl/rob_retire_ptr.sv
// Wrap-around ROB pointer advancing by 0, 1 or 2 per cycle.
module rob_ptr
  import rob_retire_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       inc,
  output logic [IDX_W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else        ptr <= ptr + IDX_W'(inc);
  end

endmodule

// File: rtl/rob_retire.sv
// Reorder buffer: dual allocation, three completion ports, dual in-order retire.
// Optional macro ROB_RETIRE_PERF_EN adds a 32-bit retired-instruction counter.
module rob_retire
  import rob_retire_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  rob_retire_if.slave      bus,
  output logic [IDX_W:0]   rob_count,
  output logic             rob_empty,
  output logic             rob_full
`ifdef ROB_RETIRE_PERF_EN
  ,
  output logic [31:0]      retired_count
`endif
);

  localparam int unsigned CNT_W = IDX_W + 1;

  rob_row           rob_q [ROB_DEPTH];
  logic [IDX_W-1:0] head, tail, head_n1, tail_n1;
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] cidx [NUM_FU];
  logic             alloc_ready, acc1, acc2, ret1, ret2;
  logic [1:0]       n_acc, n_ret;

  assign head_n1     = head + IDX_W'(1);
  assign tail_n1     = tail + IDX_W'(1);
  assign alloc_ready = (count_q <= CNT_W'(ROB_DEPTH - 2));
  assign acc1        = alloc_ready & bus.alloc_valid_1;
  assign acc2        = acc1 & bus.alloc_valid_2;
  assign ret1        = rob_q[head].v & rob_q[head].done;
  assign ret2        = ret1 & rob_q[head_n1].v & rob_q[head_n1].done;
  assign n_acc       = {acc2, acc1 & ~acc2};
  assign n_ret       = {ret2, ret1 & ~ret2};

  always_comb begin
    for (int k = 0; k < NUM_FU; k++) cidx[k] = bus.cmpl_idx[k*IDX_W +: IDX_W];
  end

  rob_ptr u_head (.clk(clk), .rst_n(rst_n), .inc(n_ret), .ptr(head));
  rob_ptr u_tail (.clk(clk), .rst_n(rst_n), .inc(n_acc), .ptr(tail));

  // Write priority: completion, then retire clear, then allocation (allocation wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (bus.cmpl_valid[k] && rob_q[cidx[k]].v) rob_q[cidx[k]].done <= 1'b1;
      end
      if (ret1) begin
        rob_q[head].v    <= 1'b0;
        rob_q[head].done <= 1'b0;
      end
      if (ret2) begin
        rob_q[head_n1].v    <= 1'b0;
        rob_q[head_n1].done <= 1'b0;
      end
      if (acc1) rob_q[tail] <= '{v: 1'b1, done: 1'b0, rd: bus.alloc_rd_1,
                                 pd: bus.alloc_pd_1, old_pd: bus.alloc_old_pd_1};
      if (acc2) rob_q[tail_n1] <= '{v: 1'b1, done: 1'b0, rd: bus.alloc_rd_2,
                                    pd: bus.alloc_pd_2, old_pd: bus.alloc_old_pd_2};
      count_q <= count_q + CNT_W'(n_acc) - CNT_W'(n_ret);
    end
  end

  assign bus.alloc_ready    = alloc_ready;
  assign bus.alloc_idx_1    = tail;
  assign bus.alloc_idx_2    = tail_n1;
  assign bus.retire_valid_1 = ret1;
  assign bus.retire_valid_2 = ret2;
  assign bus.retire_rd_1    = rob_q[head].rd;
  assign bus.retire_rd_2    = rob_q[head_n1].rd;
  assign bus.retire_pd_1    = rob_q[head].pd;
  assign bus.retire_pd_2    = rob_q[head_n1].pd;
  // x0 never received a fresh register from rename, so nothing returns to the pool.
  assign bus.free_valid_1   = ret1 & (rob_q[head].rd != '0);
  assign bus.free_valid_2   = ret2 & (rob_q[head_n1].rd != '0);
  assign bus.free_pd_1      = rob_q[head].old_pd;
  assign bus.free_pd_2      = rob_q[head_n1].old_pd;

  assign rob_count = count_q;
  assign rob_empty = (count_q == '0);
  assign rob_full  = (count_q == CNT_W'(ROB_DEPTH));

`ifdef ROB_RETIRE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_count <= '0;
    else        retired_count <= retired_count + 32'(n_ret);
  end
`endif

endmodule
